// File: rtl/reg_arb_pkg.sv
// Shared sizing constants for the register-write arbiter and its round-robin picker.
package reg_arb_pkg;
  localparam int NREQ_DEF = 4;
  localparam int NREG_DEF = 8;
  localparam int AW       = $clog2(NREG_DEF);
  localparam int CNT_W    = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: the first set bit of valid at or above ptr (wrapping) wins, one-hot.
module rr_picker #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] idx,
  output logic          hit
);
  int j;

  always_comb begin
    grant = '0;
    idx   = '0;
    hit   = 1'b0;
    j     = 0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (!hit && valid[j]) begin
        grant[j] = 1'b1;
        idx      = PW'(j);
        hit      = 1'b1;
      end
    end
  end
endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter funnelling per-requester register writes into a single
// one-cycle-latency write port, with per-requester saturating grant counters.
module reg_write_arbiter
  import reg_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int NREG = NREG_DEF,
  localparam int ADDR_W = $clog2(NREG),
  localparam int SW = $clog2(NREQ)
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic [NREQ-1:0]                    i_req_valid,
  input  logic [NREQ-1:0][ADDR_W-1:0]        i_req_addr,
  input  logic [NREQ-1:0][31:0]              i_req_data,
  output logic [NREQ-1:0]                    o_req_ready,
  input  logic                               i_stall,
  input  logic                               i_cnt_clr,
  output logic [NREG-1:0]                    o_wr_enable,
  output logic [31:0]                        o_wr_data,
  output logic [SW-1:0]                      o_wr_src,
  output logic [NREQ-1:0][CNT_W-1:0]         o_grant_cnt
);
  // Handshake: requester k transfers in any cycle where i_req_valid[k] and
  // o_req_ready[k] are both high; it must hold valid/addr/data until then.
  // Ready is combinational and at most one-hot; stall or reset forces it low.
  logic [SW-1:0]     ptr;
  logic [NREQ-1:0]   cand;
  logic [NREQ-1:0]   grant;
  logic [SW-1:0]     pick_idx;
  logic              xfer;
  logic [ADDR_W-1:0] win_addr;
  logic [NREG-1:0]   next_en;

  assign cand = (i_stall || i_rst) ? '0 : i_req_valid;

  rr_picker #(.N(NREQ), .PW(SW)) u_picker (
    .valid (cand),
    .ptr   (ptr),
    .grant (grant),
    .idx   (pick_idx),
    .hit   (xfer)
  );

  assign o_req_ready = grant;
  assign win_addr    = i_req_addr[pick_idx];

  // Register 0 is read-only zero: its writes are accepted but never enabled.
  always_comb begin
    next_en = '0;
    if (xfer && (win_addr != '0) && (int'(win_addr) < NREG))
      next_en[win_addr] = 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ptr         <= '0;
      o_wr_enable <= '0;
      o_wr_data   <= '0;
      o_wr_src    <= '0;
    end else begin
      o_wr_enable <= next_en;
      if (xfer) begin
        o_wr_data <= i_req_data[pick_idx];
        o_wr_src  <= pick_idx;
        if (int'(pick_idx) == NREQ - 1) ptr <= '0;
        else                            ptr <= pick_idx + 1'b1;
      end
    end
  end

  // Clear has priority over a same-cycle increment.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_grant_cnt <= '0;
    end else if (i_cnt_clr) begin
      o_grant_cnt <= '0;
    end else if (xfer && (o_grant_cnt[pick_idx] != CNT_MAX)) begin
      o_grant_cnt[pick_idx] <= o_grant_cnt[pick_idx] + 1'b1;
    end
  end
endmodule

// File: tb/tb_reg_write_arbiter.sv
// Randomized and directed bench for reg_write_arbiter against a queue-based reference model.
module tb_reg_write_arbiter;
  localparam int NREQ = 4;
  localparam int NREG = 8;
  localparam int W = 42;

  logic             clk;
  logic             rst;
  logic [3:0]       req_valid;
  logic [3:0][2:0]  req_addr;
  logic [3:0][31:0] req_data;
  logic [3:0]       req_ready;
  logic             stall;
  logic             cnt_clr;
  logic [7:0]       wr_enable;
  logic [31:0]      wr_data;
  logic [1:0]       wr_src;
  logic [3:0][7:0]  grant_cnt;

  reg_write_arbiter #(.NREQ(NREQ), .NREG(NREG)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req_valid (req_valid),
    .i_req_addr  (req_addr),
    .i_req_data  (req_data),
    .o_req_ready (req_ready),
    .i_stall     (stall),
    .i_cnt_clr   (cnt_clr),
    .o_wr_enable (wr_enable),
    .o_wr_data   (wr_data),
    .o_wr_src    (wr_src),
    .o_grant_cnt (grant_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model state and scoreboard
  int          checks = 0;
  int          errors = 0;
  int          m_p;
  int          m_cnt[NREQ];
  logic [1:0]  m_src;
  logic [31:0] m_data;
  logic [W-1:0] exp_q[$];
  logic [3:0]  got_rdy;
  logic [7:0]  got_en;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_p = 0;
    for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
    m_src  = '0;
    m_data = '0;
    exp_q.delete();
  endtask

  // One clock cycle: inputs were driven at the preceding negedge.
  task automatic tick();
    logic [3:0]   m_rdy;
    logic [7:0]   en;
    logic [W-1:0] e;
    logic [31:0]  mc;
    int k;
    #1;
    m_rdy = '0;
    k = -1;
    if (!stall) begin
      for (int i = 0; i < NREQ; i++) begin
        int j;
        j = (m_p + i) % NREQ;
        if (k < 0 && req_valid[j]) k = j;
      end
    end
    if (k >= 0) m_rdy[k] = 1'b1;
    chk("ready", req_ready, m_rdy);
    got_rdy = req_ready;
    en = '0;
    if (k >= 0) begin
      if (req_addr[k] != 0) en[req_addr[k]] = 1'b1;
      m_src  = 2'(k);
      m_data = req_data[k];
      m_p    = (k + 1) % NREQ;
      if (m_cnt[k] < 255) m_cnt[k]++;
    end
    if (cnt_clr) for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
    exp_q.push_back({en, m_src, m_data});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("wr_enable", wr_enable, e[41:34]);
    chk("wr_src", wr_src, e[33:32]);
    chk("wr_data", wr_data, e[31:0]);
    for (int i = 0; i < NREQ; i++) mc[i*8 +: 8] = 8'(m_cnt[i]);
    chk("grant_cnt", grant_cnt, mc);
    got_en = wr_enable;
    @(negedge clk);
  endtask

  task automatic async_reset();
    rst = 1'b1;
    #1;
    chk("rst_enable", wr_enable, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_data", wr_data, 0);
    chk("rst_src", wr_src, 0);
    chk("rst_cnt", grant_cnt, 0);
    model_reset();
    @(posedge clk);
    #1;
    chk("rst_hold_enable", wr_enable, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drive_idle();
    req_valid = '0;
    stall     = 1'b0;
    cnt_clr   = 1'b0;
  endtask

  initial begin
    logic [3:0] one;
    rst = 1'b1;
    req_addr = '0;
    req_data = '0;
    got_rdy = '0;
    got_en = '0;
    drive_idle();
    req_valid = 4'hF;
    async_reset();
    req_valid = '0;
    tick();

    // all four valid, served in index order
    req_valid = 4'hF;
    for (int i = 0; i < 4; i++) begin
      req_addr[i] = 3'(i + 1);
      req_data[i] = 32'hA0 + 32'(i);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      one = 4'b0001 << i;
      chk("rr_order", got_rdy, one);
      chk("rr_enable", got_en, 8'h02 << i);
    end
    chk("rr_counts", grant_cnt, 32'h01010101);
    req_valid = '0;

    // stall freezes arbitration and pointer
    req_valid = 4'b1010;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_ready", got_rdy, 0);
      chk("stall_enable", got_en, 0);
    end
    stall = 1'b0;
    tick();
    chk("stall_release_grant", got_rdy, 4'b0010);
    req_valid[1] = 1'b0;
    tick();
    chk("stall_second_grant", got_rdy, 4'b1000);
    req_valid = '0;

    // write to register 0 is accepted but not enabled
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    req_valid = 4'b0100;
    req_addr[2] = 3'd0;
    req_data[2] = 32'hDEADBEEF;
    tick();
    chk("reg0_ready", got_rdy, 4'b0100);
    chk("reg0_enable", got_en, 0);
    chk("reg0_cnt", grant_cnt[2], 8'd1);
    req_valid = '0;

    // counter saturation, then clear wins over a same-cycle grant
    req_valid = 4'b0001;
    req_addr[0] = 3'd3;
    for (int i = 0; i < 300; i++) tick();
    chk("sat_cnt", grant_cnt[0], 8'd255);
    cnt_clr = 1'b1;
    tick();
    chk("clr_grant", got_rdy, 4'b0001);
    chk("clr_cnt", grant_cnt[0], 8'd0);
    drive_idle();
    tick();

    // randomized traffic; ungranted requests are held unchanged
    for (int c = 0; c < 2000; c++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (!(req_valid[j] && !got_rdy[j])) begin
          req_valid[j] = 1'($urandom_range(0, 1));
          req_addr[j]  = 3'($urandom_range(0, 7));
          req_data[j]  = $urandom;
        end
      end
      stall   = ($urandom_range(0, 5) == 0);
      cnt_clr = ($urandom_range(0, 20) == 0);
      tick();
    end
    drive_idle();
    tick();

    // reset lands between a transfer and its issue edge
    req_valid = 4'b0010;
    req_addr[1] = 3'd5;
    #1;
    chk("pre_rst_ready", req_ready, 4'b0010);
    #2;
    async_reset();
    req_valid = '0;
    tick();
    chk("post_rst_enable", got_en, 0);
    req_valid = 4'hF;
    for (int i = 0; i < 4; i++) req_addr[i] = 3'(i + 4);
    tick();
    chk("post_rst_grant", got_rdy, 4'b0001);
    chk("post_rst_issue", got_en, 8'h10);
    drive_idle();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/reg_write_arbiter.md
REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 Parameter NREQ, default 4, SHALL set the number of write requesters.
REQ-002 Parameter NREG, default 8, SHALL set the number of 32-bit target registers; address width AW = clog2(NREG) = 3.
REQ-003 i_clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 i_rst  input  1  SHALL be an asynchronous, active-high reset.
REQ-005 i_req_valid  input  NREQ  SHALL be the per-requester write-request valid.
REQ-006 i_req_addr  input  NREQ x AW  SHALL be the per-requester target register index.
REQ-007 i_req_data  input  NREQ x 32  SHALL be the per-requester write data.
REQ-008 o_req_ready  output  NREQ  SHALL be the per-requester accept, at most one bit set.
REQ-009 i_stall  input  1  SHALL freeze arbitration and suppress issue while high.
REQ-010 i_cnt_clr  input  1  SHALL synchronously clear all grant counters.
REQ-011 o_wr_enable  output  NREG  SHALL be the one-hot or zero write-enable vector to the register bank.
REQ-012 o_wr_data  output  32  SHALL be the write data shared by all bank registers.
REQ-013 o_wr_src  output  clog2(NREQ)  SHALL be the index of the requester whose write is issuing.
REQ-014 o_grant_cnt  output  NREQ x 8  SHALL be the per-requester saturating accepted-write counters.

Function
REQ-015 A transfer SHALL occur for requester k when i_req_valid[k] and o_req_ready[k] are both high in the same cycle.
REQ-016 o_req_ready SHALL be combinational from i_req_valid, the priority pointer and i_stall; all bits 0 when i_stall=1 or no valid.
REQ-017 Arbitration SHALL be round-robin: search from pointer p upward modulo NREQ; first valid requester wins.
REQ-018 After a transfer by k, p SHALL become (k+1) mod NREQ; otherwise p holds (including all stall cycles).
REQ-019 A transfer in cycle n SHALL produce o_wr_enable[addr]=1, o_wr_data=data and o_wr_src=k in cycle n+1 (latency 1, single-cycle pulse).
REQ-020 A cycle with no transfer SHALL yield o_wr_enable=0 in the next cycle; o_wr_data and o_wr_src hold their last values.
REQ-021 A transfer with addr=0 SHALL be accepted and counted but SHALL produce o_wr_enable all-zero (register 0 is read-only zero).
REQ-022 A requester SHALL be able to keep valid high and win again only after every other valid requester has been served once.
REQ-023 o_grant_cnt[k] SHALL increment by 1 on each transfer by k and saturate at 255.
REQ-024 When i_cnt_clr=1 coincides with a transfer, clear SHALL win; the counter reads 0 next cycle.
REQ-025 i_stall asserted in cycle n SHALL force o_wr_enable=0 in cycle n+1; a write issued in cycle n itself is unaffected.
REQ-026 Requests not granted SHALL not be dropped; the requester holds valid, addr and data until its ready.

Reset
REQ-027 While i_rst=1: p=0, o_wr_enable=0, o_wr_data=0, o_wr_src=0, all o_grant_cnt=0, o_req_ready=0.
REQ-028 Reset asserted mid-operation SHALL discard any pending issue; no write enable pulses during or in the first cycle after reset.
REQ-029 First cycle after reset release with all valids high SHALL grant requester 0.

Structure
REQ-030 NREQ/NREG defaults, AW and counter width SHALL live in shared package reg_arb_pkg.
REQ-031 The round-robin picker (valid vector + pointer -> one-hot grant) SHALL be sub-module rr_picker; issue stage, pointer and counters stay in reg_write_arbiter.
REQ-032 Issue-stage and pointer flops SHALL use asynchronous reset; counters reset asynchronously and clear synchronously.

Verification
REQ-033 All four valid, addrs 1..4, data 0xA0..0xA3, held 4 cycles -> grants 0,1,2,3 in order; o_wr_enable = 0x02,0x04,0x08,0x10 one cycle after each; each counter = 1.
REQ-034 Requester 2 only, addr 0, data 0xDEADBEEF -> ready[2] same cycle, o_wr_enable=0 next cycle, o_grant_cnt[2]=1.
REQ-035 Requesters 1 and 3 valid, i_stall high 3 cycles then low -> no ready and no enable during stall; requester 1 granted first after release, pointer unchanged by stall.
REQ-036 Requester 0 valid continuously 300 cycles, others idle -> o_grant_cnt[0] saturates at 255; i_cnt_clr pulse coinciding with a grant -> 0 next cycle.
REQ-037 i_rst asserted asynchronously between a transfer and its issue edge -> o_wr_enable stays 0; after release, all-valid grants requester 0.
